ivs_axi_rd_mst: RTL and testbench
=================================

Name: ivs_axi_rd_mst

Overview:
AXI4 read initiator for the IVS subsystem. It is the requester-side counterpart to the AXI slave responder model on the aclk domain. It accepts single burst-read commands from a local client, issues one AR transaction, and collects the R beats. Beats are forwarded to the client over a registered valid/ready stream, and protocol errors are reported as sticky flags plus a completion pulse. It sits between IVS fetch logic and the 128-bit AXI fabric.

Parameters:
AXI_ID, 6'h00, constant arid driven on every request and expected on every rid.
CACHE, 4'b0011, constant arcache value.

Ports:
aclk  in  1  AXI clock; all logic is on its rising edge.
arest_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accept; high only in IDLE.
cmd_addr  in  64  byte address; bits [3:0] ignored.
cmd_len  in  6  beats minus 1 (1..64 beats).
arvalid  out  1  AXI AR valid.
arready  in  1  AXI AR ready.
arid  out  6  equals AXI_ID.
araddr  out  64  {cmd_addr[63:4],4'b0}.
arlen  out  6  captured cmd_len.
arsize  out  3  constant 3'b100.
arburst  out  2  constant 2'b01 (INCR).
arlock/arcache/arprot/arregion/arqos/aruser  out  1/4/3/4/4/8  arlock=0, arcache=CACHE, all others 0.
rvalid  in  1  AXI R valid.
rready  out  1  AXI R ready.
rid  in  6  response ID.
rdata  in  128  response data.
rresp  in  2  response status.
rlast  in  1  last beat.
ruser  in  5  ignored.
dout_valid  out  1  output beat valid.
dout_ready  in  1  output beat accept.
dout_data  out  128  registered rdata.
dout_last  out  1  registered rlast.
done  out  1  one-cycle pulse at end of a command.
err  out  4  sticky flags: [0] rresp!=0, [1] rid!=AXI_ID, [2] beat count vs rlast mismatch, [3] 4KB-crossing command rejected.
err_clr  in  1  clears err. If err_clr and a new error event occur in the same cycle, the new event wins.

Behaviour:
- Reset values (asynchronous, arest_n=0): state IDLE; arvalid, rready, dout_valid, dout_last, done all 0; dout_data 0; err 0; araddr and arlen 0; beat counter 0.
- Reset mid-burst abandons the transaction immediately. No completion is signalled.
- The FSM has four states: IDLE, CHK, ADDR, DATA.
  - IDLE: cmd_ready=1. On cmd_valid, capture addr and len and go to CHK.
  - CHK (one cycle): if cmd_addr[11:4] + cmd_len > 255, set err[3], pulse done, and return to IDLE. No AR is issued.
  - CHK otherwise: go to ADDR with arvalid=1.
  - ADDR: hold arvalid and all AR fields stable until arready. On arvalid&&arready, arvalid drops next cycle and the FSM goes to DATA. Latency from cmd accept to arvalid is 2 cycles.
  - DATA: rready = !dout_valid || dout_ready, a one-entry output register with no combinational path from rvalid to dout. On rvalid&&rready, load dout_data and dout_last, set dout_valid, and increment the beat counter (7-bit, wraps at 128, no saturation needed).
  - dout_valid clears on dout_ready when no new beat is loaded that cycle.
- Completion: a beat with rlast=1 ends DATA. done pulses the cycle after that beat is handshaked, and the FSM returns to IDLE at the same time, even if dout_valid is still pending. The next command may then be accepted while the last beat drains.
- Length check: err[2] sets if rlast arrives when count != arlen. It also sets at the beat where count == arlen without rlast; beats continue to be forwarded until rlast.
- Per-beat checks: err[0] sets on any accepted beat with rresp != 2'b00. err[1] sets on any accepted beat with rid != AXI_ID. Data is still forwarded in both cases.
- Only one outstanding transaction; no R interleaving is supported.
- rvalid outside DATA is ignored, with rready=0.

Test Plan:
- Basic burst: cmd addr=0x1000, len=3; slave returns 4 beats with rlast on the 4th, dout_ready=1 → araddr=0x1000, arlen=3, arsize=3'b100, arburst=2'b01. Four dout beats arrive with dout_last on the 4th, done pulses once, err=0.
- Backpressure: dout_ready=0 for 5 cycles mid-burst of len=7 → rready=0 while dout_valid=1 and unaccepted. No beat lost; data order is preserved.
- Error responses: beat 2 of 4 has rresp=2'b10 and rid=6'h05 → err=4'b0011 after that beat. err_clr clears it to 0.
- Length mismatch: len=3 but rlast on beat 2 → done pulses after beat 2, err[2]=1. Separately, len=1 with rlast on beat 4 → all 4 beats forwarded, err[2]=1.
- 4KB rejection: addr=0x0FF0, len=1 → no arvalid ever, err[3]=1, done pulses 2 cycles after cmd accept.
- Async reset asserted during DATA, beat 2 of 8 → all outputs 0 immediately. After release, cmd_ready=1 and a fresh len=0 command completes normally.

Source files
------------

// File: rtl/ivs_axi_rd_mst.sv
// rtl/ivs_axi_rd_mst.sv - AXI4 single-burst read initiator with registered beat output
module ivs_axi_rd_mst #(
  parameter logic [5:0] AXI_ID = 6'h00,
  parameter logic [3:0] CACHE  = 4'b0011
) (
  input  logic         aclk,
  input  logic         arest_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_addr,
  input  logic [5:0]   cmd_len,
  output logic         arvalid,
  input  logic         arready,
  output logic [5:0]   arid,
  output logic [63:0]  araddr,
  output logic [5:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic [3:0]   arregion,
  output logic [3:0]   arqos,
  output logic [7:0]   aruser,
  input  logic         rvalid,
  output logic         rready,
  input  logic [5:0]   rid,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic [4:0]   ruser,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout_data,
  output logic         dout_last,
  output logic         done,
  output logic [3:0]   err,
  input  logic         err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_CHK, S_ADDR, S_DATA} state_e;

  state_e         state_q, state_d;
  logic           arvalid_q, arvalid_d;
  logic [63:0]    araddr_q, araddr_d;
  logic [5:0]     arlen_q, arlen_d;
  logic [6:0]     cnt_q, cnt_d;
  logic           dout_valid_q, dout_valid_d;
  logic [127:0]   dout_data_q, dout_data_d;
  logic           dout_last_q, dout_last_d;
  logic           done_q, done_d;
  logic [3:0]     err_q, err_d;
  logic           r_hs;
  logic           crosses_4k;
  logic           at_len;
  logic           unused_ok;

  // ruser and the sub-beat address bits carry nothing this initiator needs
  assign unused_ok = ^{ruser, cmd_addr[3:0]};

  // The output register may take a new beat when it is empty or being drained this cycle
  assign rready     = (state_q == S_DATA) && (!dout_valid_q || dout_ready);
  assign r_hs       = rvalid && rready;
  assign crosses_4k = ({1'b0, araddr_q[11:4]} + {3'b000, arlen_q}) > 9'd255;
  assign at_len     = (cnt_q == {1'b0, arlen_q});

  assign cmd_ready  = (state_q == S_IDLE);
  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign arlen      = arlen_q;
  assign arid       = AXI_ID;
  assign arsize     = 3'b100;
  assign arburst    = 2'b01;
  assign arlock     = 1'b0;
  assign arcache    = CACHE;
  assign arprot     = 3'b000;
  assign arregion   = 4'b0000;
  assign arqos      = 4'b0000;
  assign aruser     = 8'h00;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_last  = dout_last_q;
  assign done       = done_q;
  assign err        = err_q;

  // Next-state, AR fields, output register and sticky error flags
  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    cnt_d        = cnt_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_last_d  = dout_last_q;
    done_d       = 1'b0;
    // a clear and a fresh error in the same cycle leaves the fresh error set
    err_d        = err_clr ? 4'b0000 : err_q;

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          araddr_d = {cmd_addr[63:4], 4'b0000};
          arlen_d  = cmd_len;
          cnt_d    = 7'd0;
          state_d  = S_CHK;
        end
      end
      S_CHK: begin
        if (crosses_4k) begin
          err_d[3] = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          dout_valid_d = 1'b1;
          dout_data_d  = rdata;
          dout_last_d  = rlast;
          cnt_d        = cnt_q + 7'd1;
          if (rresp != 2'b00) begin
            err_d[0] = 1'b1;
          end
          if (rid != AXI_ID) begin
            err_d[1] = 1'b1;
          end
          if (rlast != at_len) begin
            err_d[2] = 1'b1;
          end
          if (rlast) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state_q      <= S_IDLE;
      arvalid_q    <= 1'b0;
      araddr_q     <= 64'h0;
      arlen_q      <= 6'h0;
      cnt_q        <= 7'd0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= 128'h0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 4'h0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_last_q  <= dout_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_ivs_axi_rd_mst.sv
// tb/tb_ivs_axi_rd_mst.sv - randomized self-checking bench for ivs_axi_rd_mst
module tb_ivs_axi_rd_mst;

  logic         aclk = 1'b0;
  logic         arest_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [63:0]  cmd_addr = 64'h0;
  logic [5:0]   cmd_len = 6'h0;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [5:0]   arid;
  logic [63:0]  araddr;
  logic [5:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic [3:0]   arregion;
  logic [3:0]   arqos;
  logic [7:0]   aruser;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [5:0]   rid = 6'h0;
  logic [127:0] rdata = 128'h0;
  logic [1:0]   rresp = 2'b00;
  logic         rlast = 1'b0;
  logic [4:0]   ruser = 5'h0;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [127:0] dout_data;
  logic         dout_last;
  logic         done;
  logic [3:0]   err;
  logic         err_clr = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;
  int n_done = 0;
  int n_done_exp = 0;
  int n_ar = 0;
  int n_ar_exp = 0;
  int rdy_mode = 0;
  logic [3:0]   exp_err = 4'h0;
  logic [128:0] exp_q[$];

  ivs_axi_rd_mst dut (
    .aclk(aclk), .arest_n(arest_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arregion(arregion), .arqos(arqos), .aruser(aruser),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .ruser(ruser),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .done(done), .err(err), .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Client-side ready pattern: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b0;
      endcase
    end
  end

  // Every delivered beat must be the next one the slave sent; stalls must hold rready low
  always @(negedge aclk) begin
    logic [128:0] e;
    if (arest_n) begin
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("dout_extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout_data", dout_data, e[127:0]);
          chk("dout_last", dout_last, e[128]);
        end
      end
      if (dout_valid && !dout_ready) chk("rready_stall", rready, 0);
      if (done) n_done++;
      if (arvalid && arready) n_ar++;
    end
  end

  task automatic do_clr();
    @(posedge aclk); #1; err_clr = 1'b1;
    @(posedge aclk); #1; err_clr = 1'b0;
    @(negedge aclk);
    chk("err_clr", err, 0);
    exp_err = 4'h0;
  endtask

  task automatic do_cmd(input logic [63:0] addr, input logic [5:0] len, input int nbeats,
                        input int bad_beat, input logic [1:0] bad_resp, input logic [5:0] bad_id,
                        input bit clr_on_bad, input int abort_at);
    bit           rej;
    bit           saw_ar;
    int           n;
    logic [3:0]   run;
    logic         last;
    logic [127:0] d;
    logic [1:0]   rs;
    logic [5:0]   idv;
    // a burst of len+1 16-byte beats must end inside the 4KB page it starts in
    rej = (int'(addr[11:4]) * 16 + (int'(len) + 1) * 16) > 4096;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
    @(negedge aclk);
    chk("cmd_ready", cmd_ready, 1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0; cmd_addr = {$urandom, $urandom}; cmd_len = 6'($urandom);
    if (rej) begin
      saw_ar = 1'b0;
      for (n = 1; n <= 10; n++) begin
        @(negedge aclk);
        if (arvalid) saw_ar = 1'b1;
        if (done) break;
      end
      exp_err[3] = 1'b1;
      chk("rej_done_lat", n, 2);
      chk("rej_no_ar", saw_ar, 0);
      chk("rej_err", err, exp_err);
      n_done_exp++;
      @(negedge aclk);
      chk("rej_done_pulse", done, 0);
      return;
    end
    for (n = 1; n <= 10; n++) begin
      @(negedge aclk);
      if (arvalid) break;
    end
    chk("ar_latency", n, 2);
    chk("araddr", araddr, {addr[63:4], 4'h0});
    chk("arlen", arlen, len);
    chk("ar_const", {arid, arsize, arburst, arlock, arcache, arprot, arregion, arqos, aruser},
        {6'h00, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0, 8'h00});
    repeat ($urandom_range(0, 3)) begin
      @(posedge aclk); #1;
      rvalid = 1'b1; rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge aclk);
      chk("ar_hold", {arvalid, araddr, arlen}, {1'b1, addr[63:4], 4'h0, len});
      chk("rready_before_data", rready, 0);
    end
    @(posedge aclk); #1; rvalid = 1'b0; arready = 1'b1;
    @(posedge aclk); #1; arready = 1'b0;
    n_ar_exp++;
    run = exp_err;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_at) begin
        arest_n = 1'b0;
        #1;
        chk("rst_ctl", {arvalid, rready, dout_valid, dout_last, done, err}, 0);
        chk("rst_ar", {araddr, arlen}, 0);
        chk("rst_data", dout_data, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        exp_err = 4'h0;
        rvalid = 1'b0; rlast = 1'b0; err_clr = 1'b0;
        @(posedge aclk); #1; arest_n = 1'b1;
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk); #1;
      end
      last = (i == nbeats - 1);
      d    = {$urandom, $urandom, $urandom, $urandom};
      rs   = (i == bad_beat) ? bad_resp : 2'b00;
      idv  = (i == bad_beat) ? bad_id : 6'h00;
      rvalid = 1'b1; rdata = d; rlast = last; rresp = rs; rid = idv; ruser = 5'($urandom);
      if (clr_on_bad && i == bad_beat) err_clr = 1'b1;
      exp_q.push_back({last, d});
      for (n = 0; n < 200; n++) begin
        @(negedge aclk);
        if (n == 0) chk("err_before_beat", err, run);
        if (rready) break;
      end
      chk("rready_timeout", n < 200, 1);
      if (clr_on_bad && i == bad_beat) run = 4'h0;
      if (rs != 2'b00) run[0] = 1'b1;
      if (idv != 6'h00) run[1] = 1'b1;
      if ((i == int'(len) && !last) || (last && i != int'(len))) run[2] = 1'b1;
      @(posedge aclk); #1;
      rvalid = 1'b0; rlast = 1'b0; err_clr = 1'b0;
    end
    for (n = 1; n <= 20; n++) begin
      @(negedge aclk);
      if (done) break;
    end
    chk("done_latency", n, 1);
    chk("err_at_done", err, run);
    exp_err = run;
    n_done_exp++;
    @(negedge aclk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [63:0] addr;
    logic [5:0]  len;
    int          nb;
    int          bb;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_ctl", {cmd_ready, arvalid, rready, dout_valid, dout_last, done, err}, 10'b10_0000_0000);
    chk("reset_ar", {araddr, arlen}, 0);
    chk("reset_data", dout_data, 0);
    arest_n = 1'b1;

    rdy_mode = 0;
    do_cmd(64'h1000, 6'd3, 4, -1, 2'b00, 6'h00, 1'b0, -1);
    chk("basic_err", err, 4'b0000);

    fork
      do_cmd(64'h2008, 6'd7, 8, -1, 2'b00, 6'h00, 1'b0, -1);
      begin
        repeat (6) @(negedge aclk);
        rdy_mode = 2;
        repeat (5) @(negedge aclk);
        rdy_mode = 0;
      end
    join

    do_cmd(64'h3000, 6'd3, 4, 1, 2'b10, 6'h05, 1'b0, -1);
    chk("resp_id_err", err, 4'b0011);
    do_clr();

    do_cmd(64'h4000, 6'd3, 2, -1, 2'b00, 6'h00, 1'b0, -1);
    chk("short_burst_err", err, 4'b0100);
    do_clr();
    do_cmd(64'h4100, 6'd1, 4, -1, 2'b00, 6'h00, 1'b0, -1);
    chk("long_burst_err", err, 4'b0100);
    do_clr();

    do_cmd(64'h0FF0, 6'd1, 2, -1, 2'b00, 6'h00, 1'b0, -1);
    chk("cross_4k_err", err, 4'b1000);
    do_cmd(64'h0FF0, 6'd0, 1, -1, 2'b00, 6'h00, 1'b0, -1);
    chk("edge_4k_ok", err, 4'b1000);
    do_cmd(64'h7000, 6'd2, 3, 0, 2'b01, 6'h00, 1'b1, -1);
    chk("clr_vs_new_err", err, 4'b0001);
    do_clr();

    do_cmd(64'h5000, 6'd7, 8, -1, 2'b00, 6'h00, 1'b0, 2);
    do_cmd(64'h6000, 6'd0, 1, -1, 2'b00, 6'h00, 1'b0, -1);
    chk("after_reset_err", err, 4'b0000);

    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      len  = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 15));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) addr[11:4] = 8'(255 - int'(len) + int'($urandom_range(0, 3)));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : int'(len) + 1;
      bb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      do_cmd(addr, len, nb, bb, 2'($urandom), 6'($urandom), $urandom_range(0, 5) == 0, -1);
      if ($urandom_range(0, 4) == 0) do_clr();
    end

    rdy_mode = 0;
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge aclk);
    chk("drain_empty", exp_q.size(), 0);
    chk("done_count", n_done, n_done_exp);
    chk("ar_count", n_ar, n_ar_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_mis);
    $fatal(1, "timeout");
  end

endmodule
